link_sync_ctrl: RTL and testbench

//  Word-alignment and link-synchronisation controller for the serial-to-parallel receive path, in the clk_f domain.
//  - Watches the 8-bit words from the deserializer for the COMMA idle (8'hBC).
//  - Pulses slip_out to shift the deserializer word boundary by one bit until commas appear.
//  - Declares lock after LOCK_COUNT consecutive commas and forwards payload words with a valid qualifier.
//  - Drops lock after UNLOCK_COUNT consecutive errored words.

---
 rtl/link_sync_pkg.sv | 26 ++
 rtl/link_sync_if.sv | 25 ++
 rtl/link_sync_sat_cnt.sv | 24 ++
 rtl/link_sync_ctrl.sv | 156 +++++++++++++++
 tb/tb_link_sync_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/link_sync_pkg.sv
// Shared types and defaults for the link word-alignment controller.
package link_sync_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_HOLD = 2'd1,
    ST_CHECK     = 2'd2,
    ST_LOCKED    = 2'd3
  } state_e;

  localparam logic [7:0] COMMA_DEFAULT          = 8'hBC;
  localparam int         LOCK_COUNT_DEFAULT     = 4;
  localparam int         UNLOCK_COUNT_DEFAULT   = 4;
  localparam int         SEARCH_TIMEOUT_DEFAULT = 16;
  localparam int         SLIP_WAIT_DEFAULT      = 8;

  function automatic logic is_clean(
    input logic [7:0] w,
    input logic       v,
    input logic       e,
    input logic [7:0] sym
  );
    return v && !e && (w == sym);
  endfunction

endpackage

// File: rtl/link_sync_if.sv
// Deserializer-facing word bus and controller status outputs.
interface link_sync_if;
  import link_sync_pkg::*;

  logic [7:0] word_in;
  logic       word_valid;
  logic       word_err;
  logic       slip_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic       synced;
  logic [1:0] state_out;

  modport master (
    output word_in, word_valid, word_err,
    input  slip_out, data_out, valid_out,
    input  synced, state_out
  );

  modport slave (
    input  word_in, word_valid, word_err,
    output slip_out, data_out, valid_out,
    output synced, state_out
  );
endinterface

// File: rtl/link_sync_sat_cnt.sv
// Saturating event counter with synchronous clear.
module link_sync_sat_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/link_sync_ctrl.sv
// Comma word-alignment and lock controller for the receive path.
// Optional slip/lock-loss statistics under LINK_SYNC_STATS_EN.
module link_sync_ctrl
  import link_sync_pkg::*;
#(
  parameter logic [7:0] COMMA          = COMMA_DEFAULT,
  parameter int         LOCK_COUNT     = LOCK_COUNT_DEFAULT,
  parameter int         UNLOCK_COUNT   = UNLOCK_COUNT_DEFAULT,
  parameter int         SEARCH_TIMEOUT = SEARCH_TIMEOUT_DEFAULT,
  parameter int         SLIP_WAIT      = SLIP_WAIT_DEFAULT
) (
  input  logic       i_clk_f,
  input  logic       i_reset,
  link_sync_if.slave bus
`ifdef LINK_SYNC_STATS_EN
  ,
  output logic [7:0] o_slip_cnt,
  output logic [7:0] o_lock_loss_cnt
`endif
);

  localparam int MW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam int TW = $clog2(SLIP_WAIT + 1);

  state_e        r_state;
  logic [MW-1:0] r_miss;
  logic [CW-1:0] r_comma;
  logic [BW-1:0] r_bad;
  logic [TW-1:0] r_timer;
  logic          r_slip;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_synced;

  logic w_vld;
  logic w_comma;
  logic w_slip_evt;
  logic w_loss_evt;
  logic w_lock_evt;

  assign w_vld   = bus.word_valid;
  assign w_comma = is_clean(bus.word_in, bus.word_valid,
                            bus.word_err, COMMA);

  assign w_slip_evt = (r_state == ST_SEARCH) && w_vld && !w_comma
                   && (r_miss == MW'(SEARCH_TIMEOUT - 1));

  assign w_loss_evt = (r_state == ST_LOCKED) && w_vld && bus.word_err
                   && (r_bad == BW'(UNLOCK_COUNT - 1));

  // Lock from SEARCH only when a single comma suffices.
  assign w_lock_evt = w_comma && (
      ((r_state == ST_SEARCH) && (LOCK_COUNT == 1))
   || ((r_state == ST_CHECK)
       && (r_comma == CW'(LOCK_COUNT - 1))));

  always_ff @(posedge i_clk_f) begin
    if (i_reset) begin
      r_state  <= ST_SEARCH;
      r_miss   <= '0;
      r_comma  <= '0;
      r_bad    <= '0;
      r_timer  <= '0;
      r_slip   <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_synced <= 1'b0;
    end else begin
      r_slip  <= 1'b0;
      r_valid <= 1'b0;
      unique case (r_state)
        ST_SEARCH: begin
          if (w_lock_evt) begin
            r_state  <= ST_LOCKED;
            r_synced <= 1'b1;
            r_miss   <= '0;
          end else if (w_comma) begin
            r_state <= ST_CHECK;
            r_comma <= CW'(1);
            r_miss  <= '0;
          end else if (w_slip_evt) begin
            r_state <= ST_SLIP_HOLD;
            r_slip  <= 1'b1;
            r_miss  <= '0;
            r_timer <= '0;
          end else if (w_vld) begin
            r_miss <= r_miss + 1'b1;
          end
        end
        ST_SLIP_HOLD: begin
          if (r_timer == TW'(SLIP_WAIT - 1)) begin
            r_state <= ST_SEARCH;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_lock_evt) begin
            r_state  <= ST_LOCKED;
            r_synced <= 1'b1;
            r_comma  <= '0;
          end else if (w_comma) begin
            r_comma <= r_comma + 1'b1;
          end else if (w_vld) begin
            r_state <= ST_SEARCH;
            r_comma <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_loss_evt) begin
            r_state  <= ST_SEARCH;
            r_synced <= 1'b0;
            r_bad    <= '0;
          end else if (w_vld && bus.word_err) begin
            r_bad <= r_bad + 1'b1;
          end else if (w_vld) begin
            r_bad <= '0;
            if (!w_comma) begin
              r_data  <= bus.word_in;
              r_valid <= 1'b1;
            end
          end
        end
        default: r_state <= ST_SEARCH;
      endcase
    end
  end

  assign bus.slip_out  = r_slip;
  assign bus.data_out  = r_data;
  assign bus.valid_out = r_valid;
  assign bus.synced    = r_synced;
  assign bus.state_out = r_state;

`ifdef LINK_SYNC_STATS_EN
  link_sync_sat_cnt #(.W(8)) u_slip_cnt (
    .i_clk (i_clk_f),
    .i_rst (i_reset),
    .i_clr (1'b0),
    .i_inc (w_slip_evt),
    .o_cnt (o_slip_cnt)
  );

  link_sync_sat_cnt #(.W(8)) u_loss_cnt (
    .i_clk (i_clk_f),
    .i_rst (i_reset),
    .i_clr (1'b0),
    .i_inc (w_loss_evt),
    .o_cnt (o_lock_loss_cnt)
  );
`endif

endmodule

// File: tb/tb_link_sync_ctrl.sv
// Directed bench for link_sync_ctrl with a payload scoreboard.
// Stats outputs are checked when LINK_SYNC_STATS_EN is defined.
module tb_link_sync_ctrl;
  import link_sync_pkg::*;

  logic clk_f = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] sb[$];

  link_sync_if bus();

`ifdef LINK_SYNC_STATS_EN
  logic [7:0] slip_cnt;
  logic [7:0] loss_cnt;
`endif

  link_sync_ctrl dut (
    .i_clk_f (clk_f),
    .i_reset (reset),
    .bus     (bus)
`ifdef LINK_SYNC_STATS_EN
    ,
    .o_slip_cnt      (slip_cnt),
    .o_lock_loss_cnt (loss_cnt)
`endif
  );

  always #5 clk_f = ~clk_f;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Present one word, then wait past the edge that samples it.
  task automatic drive(input logic [7:0] w,
                       input logic v,
                       input logic e);
    bus.word_in    = w;
    bus.word_valid = v;
    bus.word_err   = e;
    @(posedge clk_f);
    #1;
  endtask

  task automatic payload(input logic [7:0] w);
    sb.push_back(w);
    drive(w, 1'b1, 1'b0);
  endtask

  task automatic lock_up();
    for (int i = 0; i < 4; i++) drive(8'hBC, 1'b1, 1'b0);
    chk("lock_synced", {7'd0, bus.synced}, 8'd1);
  endtask

  task automatic miss_run(input int n, input string tag);
    for (int i = 0; i < n - 1; i++) begin
      drive(8'h3C, 1'b1, 1'b0);
      if (bus.slip_out) chk({tag, "_early"}, 8'd1, 8'd0);
    end
    drive(8'h3C, 1'b1, 1'b0);
    chk({tag, "_slip"}, {7'd0, bus.slip_out}, 8'd1);
    chk({tag, "_st"}, {6'd0, bus.state_out}, 8'd1);
  endtask

  always @(negedge clk_f) begin
    if (bus.valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_extra: observed %0h expected none",
               bus.data_out);
      end else begin
        chk("sb_data", bus.data_out, sb.pop_front());
      end
    end
  end

  initial begin
    bus.word_in    = 8'hBC;
    bus.word_valid = 1'b1;
    bus.word_err   = 1'b0;

    // 1: reset with commas held
    for (int i = 0; i < 2; i++) begin
      drive(8'hBC, 1'b1, 1'b0);
      chk("rst_state", {6'd0, bus.state_out}, 8'd0);
      chk("rst_valid", {7'd0, bus.valid_out}, 8'd0);
      chk("rst_synced", {7'd0, bus.synced}, 8'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive(8'hBC, 1'b1, 1'b0);
    chk("chk3_synced", {7'd0, bus.synced}, 8'd0);
    chk("chk3_state", {6'd0, bus.state_out}, 8'd2);
    drive(8'hBC, 1'b1, 1'b0);
    chk("lock1_synced", {7'd0, bus.synced}, 8'd1);
    chk("lock1_state", {6'd0, bus.state_out}, 8'd3);

    // 4: payload with stalls, comma dropped
    payload(8'h11);
    chk("p11_valid", {7'd0, bus.valid_out}, 8'd1);
    drive(8'h00, 1'b0, 1'b0);
    chk("stall_valid", {7'd0, bus.valid_out}, 8'd0);
    chk("hold_data", bus.data_out, 8'h11);
    drive(8'hBC, 1'b1, 1'b0);
    chk("bc_valid", {7'd0, bus.valid_out}, 8'd0);
    drive(8'h00, 1'b0, 1'b0);
    payload(8'h22);
    chk("p22_data", bus.data_out, 8'h22);
    drive(8'h00, 1'b0, 1'b0);

    // 5: error runs
    for (int i = 0; i < 3; i++) drive(8'h77, 1'b1, 1'b1);
    chk("err3_synced", {7'd0, bus.synced}, 8'd1);
    payload(8'h33);
    for (int i = 0; i < 3; i++) drive(8'h77, 1'b1, 1'b1);
    chk("err7_synced", {7'd0, bus.synced}, 8'd1);
    drive(8'h77, 1'b1, 1'b1);
    chk("loss_synced", {7'd0, bus.synced}, 8'd0);
    chk("loss_state", {6'd0, bus.state_out}, 8'd0);
    chk("loss_valid", {7'd0, bus.valid_out}, 8'd0);
`ifdef LINK_SYNC_STATS_EN
    chk("loss_cnt", loss_cnt, 8'd1);
`endif

    // 2: slip after 16 misses, 8-cycle hold
    miss_run(16, "slip1");
    for (int i = 0; i < 7; i++) begin
      drive(8'h3C, 1'b1, 1'b0);
      chk("hold_st", {6'd0, bus.state_out}, 8'd1);
      chk("hold_slip", {7'd0, bus.slip_out}, 8'd0);
    end
    drive(8'hBC, 1'b1, 1'b0);
    chk("hold_done", {6'd0, bus.state_out}, 8'd0);
    miss_run(16, "slip2");
`ifdef LINK_SYNC_STATS_EN
    chk("slip_cnt", slip_cnt, 8'd2);
`endif
    for (int i = 0; i < 8; i++) drive(8'h3C, 1'b0, 1'b0);
    chk("hold2_done", {6'd0, bus.state_out}, 8'd0);

    // 3: broken comma run, then lock
    for (int i = 0; i < 3; i++) drive(8'hBC, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0);
    chk("brk_state", {6'd0, bus.state_out}, 8'd0);
    chk("brk_synced", {7'd0, bus.synced}, 8'd0);
    chk("brk_slip", {7'd0, bus.slip_out}, 8'd0);
    lock_up();

    // 6: reset while streaming, then inside the hold
    payload(8'h44);
    reset = 1'b1;
    drive(8'h55, 1'b1, 1'b0);
    chk("r1_state", {6'd0, bus.state_out}, 8'd0);
    chk("r1_valid", {7'd0, bus.valid_out}, 8'd0);
    chk("r1_data", bus.data_out, 8'h00);
    chk("r1_synced", {7'd0, bus.synced}, 8'd0);
    reset = 1'b0;
    miss_run(16, "slip3");
    drive(8'h3C, 1'b1, 1'b0);
    reset = 1'b1;
    drive(8'h3C, 1'b1, 1'b0);
    chk("r2_state", {6'd0, bus.state_out}, 8'd0);
    chk("r2_slip", {7'd0, bus.slip_out}, 8'd0);
`ifdef LINK_SYNC_STATS_EN
    chk("r2_slipcnt", slip_cnt, 8'd0);
    chk("r2_losscnt", loss_cnt, 8'd0);
`endif
    reset = 1'b0;
    drive(8'h3C, 1'b1, 1'b0);
    chk("r2_post_slip", {7'd0, bus.slip_out}, 8'd0);
    chk("r2_post_state", {6'd0, bus.state_out}, 8'd0);

    chk("sb_left", 8'(sb.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
